// File: rtl/mem_bank_side.sv
// mem_bank_side: one (even or odd) side of the main-memory model.
// Holds two request FIFOs (data-side and instruction-side), a fixed-priority
// selector (data side first) and a single line-granular DRAM bank with a
// fixed access latency. Returns one response per request, in service order.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   *_in_data_q              data-side request (addr, line data, op, tags)
//   alloc_in_data_q          data-side push strobe
//   full_out_data_q          data FIFO full
//   *_in_instr_q             instruction-side request (no data)
//   alloc_in_instr_q         instruction-side push strobe
//   full_out_instr_q         instruction FIFO full
//   addr_out .. dest_out     response fields, alloc_out = response valid
//   full_in                  downstream response queue full (stalls RESP)

module mem_bank_side_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rd];
  // Push is judged on the registered count: a push while full is dropped
  // even if the head is popped in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// Bank FSM
//   state  | meaning
//   S_IDLE | no request in flight, accepts a FIFO head if one is valid
//   S_BUSY | access in progress, latency counter running down
//   S_RESP | response valid (alloc_out=1), held while full_in=1
module mem_bank_side #(
  parameter int CL_SIZE    = 128,
  parameter int Q_LENGTH   = 8,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr_in_data_q,
  input  logic [CL_SIZE-1:0] data_in_data_q,
  input  logic [2:0]         operation_in_data_q,
  input  logic               is_flush_in_data_q,
  input  logic               alloc_in_data_q,
  input  logic [1:0]         src_in_data_q,
  input  logic [1:0]         dest_in_data_q,
  output logic               full_out_data_q,
  input  logic [31:0]        addr_in_instr_q,
  input  logic [2:0]         operation_in_instr_q,
  input  logic               is_flush_in_instr_q,
  input  logic               alloc_in_instr_q,
  input  logic [1:0]         src_in_instr_q,
  input  logic [1:0]         dest_in_instr_q,
  output logic               full_out_instr_q,
  output logic [31:0]        addr_out,
  output logic [CL_SIZE-1:0] data_out,
  output logic [2:0]         operation_out,
  output logic               is_flush_out,
  output logic               alloc_out,
  output logic [1:0]         src_out,
  output logic [1:0]         dest_out,
  input  logic               full_in
);
  localparam int DW    = 32 + CL_SIZE + 3 + 1 + 2 + 2;
  localparam int IW    = 32 + 3 + 1 + 2 + 2;
  localparam int CNTW  = $clog2(LATENCY + 1);
  localparam int LINES = 2 ** INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [CNTW-1:0]       r_cnt;
  logic [CL_SIZE-1:0]    r_mem [LINES];
  logic [31:0]           r_addr;
  logic [CL_SIZE-1:0]    r_data;
  logic [2:0]            r_op;
  logic                  r_flush;
  logic [1:0]            r_src;
  logic [1:0]            r_dest;

  logic [DW-1:0]         w_d_dout;
  logic [IW-1:0]         w_i_dout;
  logic                  w_d_empty, w_i_empty;
  logic                  w_acc_data, w_acc_instr, w_accept;
  logic [31:0]           w_d_addr, w_i_addr, w_sel_addr;
  logic [CL_SIZE-1:0]    w_d_data, w_sel_data;
  logic [2:0]            w_d_op, w_i_op, w_sel_op;
  logic                  w_d_flush, w_i_flush, w_sel_flush;
  logic [1:0]            w_d_src, w_i_src, w_sel_src;
  logic [1:0]            w_d_dest, w_i_dest, w_sel_dest;
  logic [INDEX_BITS-1:0] w_idx;
  logic                  w_is_write;

  mem_bank_side_fifo #(.W(DW), .DEPTH(Q_LENGTH)) u_data_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (alloc_in_data_q),
    .i_din   ({addr_in_data_q, data_in_data_q, operation_in_data_q,
               is_flush_in_data_q, src_in_data_q, dest_in_data_q}),
    .i_pop   (w_acc_data),
    .o_dout  (w_d_dout),
    .o_empty (w_d_empty),
    .o_full  (full_out_data_q)
  );

  mem_bank_side_fifo #(.W(IW), .DEPTH(Q_LENGTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (alloc_in_instr_q),
    .i_din   ({addr_in_instr_q, operation_in_instr_q, is_flush_in_instr_q,
               src_in_instr_q, dest_in_instr_q}),
    .i_pop   (w_acc_instr),
    .o_dout  (w_i_dout),
    .o_empty (w_i_empty),
    .o_full  (full_out_instr_q)
  );

  assign {w_d_addr, w_d_data, w_d_op, w_d_flush, w_d_src, w_d_dest} = w_d_dout;
  assign {w_i_addr, w_i_op, w_i_flush, w_i_src, w_i_dest}           = w_i_dout;

  // Data side has fixed priority; instruction requests carry a zero line.
  assign w_acc_data  = (r_state == S_IDLE) && !w_d_empty;
  assign w_acc_instr = (r_state == S_IDLE) && w_d_empty && !w_i_empty;
  assign w_accept    = w_acc_data || w_acc_instr;

  assign w_sel_addr  = w_acc_data ? w_d_addr  : w_i_addr;
  assign w_sel_data  = w_acc_data ? w_d_data  : '0;
  assign w_sel_op    = w_acc_data ? w_d_op    : w_i_op;
  assign w_sel_flush = w_acc_data ? w_d_flush : w_i_flush;
  assign w_sel_src   = w_acc_data ? w_d_src   : w_i_src;
  assign w_sel_dest  = w_acc_data ? w_d_dest  : w_i_dest;

  // addr[4] picks the even/odd side upstream, so the line index starts at bit 5.
  assign w_idx      = w_sel_addr[4+INDEX_BITS:5];
  assign w_is_write = (w_sel_op == 3'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) r_mem[i] <= '0;
    end else if (w_accept && w_is_write) begin
      r_mem[w_idx] <= w_sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op    <= '0;
      r_flush <= 1'b0;
      r_src   <= '0;
      r_dest  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= CNTW'(LATENCY);
            r_addr  <= w_sel_addr;
            // One access in flight, so the array read already reflects every
            // earlier write; a write returns its own data.
            r_data  <= w_is_write ? w_sel_data : r_mem[w_idx];
            r_op    <= w_sel_op;
            r_flush <= w_sel_flush;
            // Response is routed back to the requester.
            r_src   <= w_sel_dest;
            r_dest  <= w_sel_src;
          end
        end
        S_BUSY: begin
          if (r_cnt == CNTW'(1)) r_state <= S_RESP;
          else                   r_cnt   <= r_cnt - 1'b1;
        end
        S_RESP: begin
          if (!full_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alloc_out     = (r_state == S_RESP);
  assign addr_out      = r_addr;
  assign data_out      = r_data;
  assign operation_out = r_op;
  assign is_flush_out  = r_flush;
  assign src_out       = r_src;
  assign dest_out      = r_dest;
endmodule

// File: tb/tb_mem_bank_side.sv
// tb_mem_bank_side: directed bench for mem_bank_side with hand-computed
// expected responses. Inputs change and outputs are sampled 2 ns after the
// rising edge; completed responses are logged at the falling edge.

module tb_mem_bank_side;
  localparam int LAT = 4;
  localparam logic [127:0] D = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] E = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] F = 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4444;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr_in_data_q = '0;
  logic [127:0] data_in_data_q = '0;
  logic [2:0]   operation_in_data_q = '0;
  logic         is_flush_in_data_q = 1'b0;
  logic         alloc_in_data_q = 1'b0;
  logic [1:0]   src_in_data_q = '0;
  logic [1:0]   dest_in_data_q = '0;
  logic         full_out_data_q;
  logic [31:0]  addr_in_instr_q = '0;
  logic [2:0]   operation_in_instr_q = '0;
  logic         is_flush_in_instr_q = 1'b0;
  logic         alloc_in_instr_q = 1'b0;
  logic [1:0]   src_in_instr_q = '0;
  logic [1:0]   dest_in_instr_q = '0;
  logic         full_out_instr_q;
  logic [31:0]  addr_out;
  logic [127:0] data_out;
  logic [2:0]   operation_out;
  logic         is_flush_out;
  logic         alloc_out;
  logic [1:0]   src_out;
  logic [1:0]   dest_out;
  logic         full_in = 1'b0;

  mem_bank_side #(.CL_SIZE(128), .Q_LENGTH(8), .INDEX_BITS(10), .LATENCY(LAT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .addr_in_data_q       (addr_in_data_q),
    .data_in_data_q       (data_in_data_q),
    .operation_in_data_q  (operation_in_data_q),
    .is_flush_in_data_q   (is_flush_in_data_q),
    .alloc_in_data_q      (alloc_in_data_q),
    .src_in_data_q        (src_in_data_q),
    .dest_in_data_q       (dest_in_data_q),
    .full_out_data_q      (full_out_data_q),
    .addr_in_instr_q      (addr_in_instr_q),
    .operation_in_instr_q (operation_in_instr_q),
    .is_flush_in_instr_q  (is_flush_in_instr_q),
    .alloc_in_instr_q     (alloc_in_instr_q),
    .src_in_instr_q       (src_in_instr_q),
    .dest_in_instr_q      (dest_in_instr_q),
    .full_out_instr_q     (full_out_instr_q),
    .addr_out             (addr_out),
    .data_out             (data_out),
    .operation_out        (operation_out),
    .is_flush_out         (is_flush_out),
    .alloc_out            (alloc_out),
    .src_out              (src_out),
    .dest_out             (dest_out),
    .full_in              (full_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [2:0]   op;
    logic         fl;
    logic [1:0]   src;
    logic [1:0]   dest;
    int           cyc;
  } resp_t;

  resp_t rq[$];
  int    cyc_n = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (alloc_out && !full_in)
      rq.push_back('{addr_out, data_out, operation_out, is_flush_out, src_out, dest_out, cyc_n});
  end

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] mkr(input logic [31:0] a, input logic [127:0] d,
                                       input logic [2:0] op, input logic fl,
                                       input logic [1:0] s, input logic [1:0] de);
    return {32'b0, a, d, op, fl, s, de};
  endfunction

  function automatic logic [199:0] rpack(input resp_t r);
    return {32'b0, r.addr, r.data, r.op, r.fl, r.src, r.dest};
  endfunction

  function automatic logic [199:0] ob(input logic a, input logic fd, input logic fi,
                                      input logic [31:0] ad, input logic [127:0] d,
                                      input logic [2:0] op, input logic fl,
                                      input logic [1:0] s, input logic [1:0] de);
    return {29'b0, a, fd, fi, ad, d, op, fl, s, de};
  endfunction

  function automatic logic [199:0] obs();
    return ob(alloc_out, full_out_data_q, full_out_instr_q, addr_out, data_out,
              operation_out, is_flush_out, src_out, dest_out);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [31:0] a, input logic [127:0] d, input logic [2:0] op,
                       input logic fl, input logic [1:0] s, input logic [1:0] de);
    addr_in_data_q = a; data_in_data_q = d; operation_in_data_q = op;
    is_flush_in_data_q = fl; src_in_data_q = s; dest_in_data_q = de;
    alloc_in_data_q = 1'b1;
  endtask

  task automatic set_i(input logic [31:0] a, input logic [2:0] op, input logic fl,
                       input logic [1:0] s, input logic [1:0] de);
    addr_in_instr_q = a; operation_in_instr_q = op; is_flush_in_instr_q = fl;
    src_in_instr_q = s; dest_in_instr_q = de;
    alloc_in_instr_q = 1'b1;
  endtask

  task automatic push_end();
    step();
    alloc_in_data_q  = 1'b0;
    alloc_in_instr_q = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && rq.size() < n; k++) step();
    chk(tag, rq.size(), n);
  endtask

  task automatic wait_alloc(input string tag, input int budget);
    for (int k = 0; k < budget && !alloc_out; k++) step();
    chk(tag, alloc_out, 1'b1);
  endtask

  initial begin
    int pe;
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe;

    // Reset, then idle: everything stays zero.
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("idle_zero", obs(), '0);
      step();
    end

    // WRITE via data queue, READ same line via instr queue.
    rq.delete();
    set_d(32'h40, D, 3'd2, 1'b0, 2'd1, 2'd2);
    push_end();
    set_i(32'h40, 3'd1, 1'b0, 2'd3, 2'd0);
    push_end();
    wait_resp("wr_rd_count", 2, 40);
    if (rq.size() >= 2) begin
      chk("wr_resp", rpack(rq[0]), mkr(32'h40, D, 3'd2, 1'b0, 2'd2, 2'd1));
      chk("rd_resp", rpack(rq[1]), mkr(32'h40, D, 3'd1, 1'b0, 2'd0, 2'd3));
      chk("wr_rd_gap", rq[1].cyc - rq[0].cyc, LAT + 2);
    end
    repeat (3) step();

    // Same-cycle pushes: data side first; op 5 behaves as READ.
    rq.delete();
    pe = cyc_n + 1;
    set_d(32'h80, D, 3'd1, 1'b0, 2'd1, 2'd0);
    set_i(32'h40, 3'd5, 1'b1, 2'd2, 2'd3);
    push_end();
    wait_resp("prio_count", 2, 40);
    if (rq.size() >= 2) begin
      chk("prio_first", rpack(rq[0]), mkr(32'h80, '0, 3'd1, 1'b0, 2'd0, 2'd1));
      chk("prio_lat", rq[0].cyc, pe + 1 + LAT);
      chk("prio_second", rpack(rq[1]), mkr(32'h40, D, 3'd5, 1'b1, 2'd3, 2'd2));
      chk("prio_gap", rq[1].cyc - rq[0].cyc, LAT + 2);
    end
    repeat (3) step();

    // Stall the bank in RESP, then overfill the data FIFO.
    rq.delete();
    full_in = 1'b1;
    set_i(32'h200, 3'd1, 1'b0, 2'd0, 2'd1);
    push_end();
    wait_alloc("stall_alloc", 20);
    for (int i = 0; i < 9; i++) begin
      set_d(32'h400 + 32'(i) * 32'h20, '0, 3'd1, 1'b0, 2'd1, 2'd2);
      step();
      chk("fill_full", full_out_data_q, i >= 7);
    end
    alloc_in_data_q = 1'b0;
    chk("fill_instr_full", full_out_instr_q, 1'b0);
    full_in = 1'b0;
    step();
    chk("full_before_pop", full_out_data_q, 1'b1);
    step();
    chk("full_after_pop", full_out_data_q, 1'b0);
    wait_resp("fill_count", 9, 200);
    repeat (20) step();
    chk("fill_no_extra", rq.size(), 9);
    if (rq.size() >= 9) begin
      chk("fill_prime", rpack(rq[0]), mkr(32'h200, '0, 3'd1, 1'b0, 2'd1, 2'd0));
      for (int i = 0; i < 8; i++)
        chk("fill_order", rpack(rq[i+1]),
            mkr(32'h400 + 32'(i) * 32'h20, '0, 3'd1, 1'b0, 2'd2, 2'd1));
    end

    // Hold in RESP: outputs stable until full_in drops, one response.
    rq.delete();
    full_in = 1'b1;
    set_d(32'h60, E, 3'd2, 1'b1, 2'd2, 2'd3);
    push_end();
    wait_alloc("hold_alloc", 20);
    for (int k = 0; k < 4; k++) begin
      chk("hold_stable", obs(), ob(1'b1, 1'b0, 1'b0, 32'h60, E, 3'd2, 1'b1, 2'd3, 2'd2));
      step();
    end
    chk("hold_no_resp", rq.size(), 0);
    full_in = 1'b0;
    step();
    chk("hold_released", alloc_out, 1'b0);
    repeat (5) step();
    chk("hold_count", rq.size(), 1);
    if (rq.size() >= 1)
      chk("hold_resp", rpack(rq[0]), mkr(32'h60, E, 3'd2, 1'b1, 2'd3, 2'd2));

    // Reset during an access: nothing comes out, memory cleared.
    rq.delete();
    set_d(32'h40, F, 3'd2, 1'b0, 2'd1, 2'd1);
    set_i(32'h60, 3'd1, 1'b0, 2'd0, 2'd0);
    push_end();
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (12) step();
    chk("rst_no_resp", rq.size(), 0);
    chk("rst_outputs", obs(), '0);
    set_d(32'h40, '0, 3'd1, 1'b0, 2'd1, 2'd2);
    set_i(32'h60, 3'd1, 1'b0, 2'd3, 2'd0);
    push_end();
    wait_resp("rst_read_count", 2, 40);
    if (rq.size() >= 2) begin
      chk("rst_read_40", rpack(rq[0]), mkr(32'h40, '0, 3'd1, 1'b0, 2'd2, 2'd1));
      chk("rst_read_60", rpack(rq[1]), mkr(32'h60, '0, 3'd1, 1'b0, 2'd0, 2'd3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bank_side.md
# mem_bank_side

One side (even or odd) of the main-memory model: two request FIFOs (data-side and instruction-side), a fixed-priority selector, and a single cache-line-granular DRAM bank with fixed access latency. It sits between the L2/cache miss paths and the memory response queue, returning one response per request in service order.

## Interface
- CL_SIZE, 128, cache-line width in bits
- Q_LENGTH, 8, depth of each request FIFO
- INDEX_BITS, 10, log2 of lines held by the bank
- LATENCY, 4, cycles from request accept to response valid (≥1)

- clk  in  1  clock; single clock domain, all logic rising-edge
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- addr_in_data_q / data_in_data_q / operation_in_data_q  in  32 / CL_SIZE / 3  data-queue request
- is_flush_in_data_q, alloc_in_data_q  in  1 each  flush tag; push strobe
- src_in_data_q, dest_in_data_q  in  2 each  requester / target IDs
- full_out_data_q  out  1  data FIFO holds Q_LENGTH entries
- addr_in_instr_q, operation_in_instr_q, is_flush_in_instr_q, alloc_in_instr_q, src_in_instr_q, dest_in_instr_q  in  32/3/1/1/2/2  instruction-queue request (no data)
- full_out_instr_q  out  1  instr FIFO full
- addr_out, data_out, operation_out  out  32 / CL_SIZE / 3  response
- is_flush_out, alloc_out, src_out, dest_out  out  1/1/2/2  response tags; alloc_out = response valid
- full_in  in  1  downstream response queue full

## Operation
- FIFOs: push on alloc when not full; alloc while full is dropped (even if a pop occurs the same cycle). Pop only when selector accepts the head. Pointers wrap modulo Q_LENGTH; full = count==Q_LENGTH. Instruction entries carry data = 0.
- Selector: bank idle and a head valid → accept. Data FIFO has fixed priority over instr FIFO. Exactly one pop per accept.
- Operations: 3'd1 READ, 3'd2 WRITE; all other codes treated as READ.
- Line index = addr[4+INDEX_BITS:5] (addr[3:0] byte offset, addr[4] bank select, ignored here).
- WRITE: line written with data at accept edge; response data = written data.
- READ: line read at accept edge (reflects all earlier-accepted writes); response data = line.
- Response fields: addr, operation, is_flush copied from request; src_out = request dest, dest_out = request src.
- Bank states: IDLE → BUSY (counter = LATENCY on accept) → RESP (alloc_out=1) → IDLE. In RESP with full_in=1, hold all outputs and alloc_out until full_in=0; then leave RESP after one cycle with full_in=0.
- Memory array resets to all zero.

## Timing
- Reset: FIFOs empty, full_out_* = 0, bank IDLE, alloc_out = 0, all response outputs 0, memory zero.
- Push at edge T: entry visible at head for selection after edge T; earliest accept at edge T+1.
- Accept at edge A: response alloc_out=1 during cycle after edge A+LATENCY (if full_in=0), valid exactly one cycle.
- Next accept no earlier than the edge ending the RESP cycle's following IDLE cycle; one request in flight.
- full_out_* reflect registered count; rise the cycle after the push filling the last slot; fall the cycle after a pop from full.
- Reset asserted mid-operation: in-flight request and queued entries discarded, no response issued.

## Test plan
- Reset then idle: all outputs 0, full_out_* 0 for 20 cycles.
- WRITE addr 0x40 data 0xDEADBEEF… via data queue, then READ 0x40 via instr queue → two responses in order, read data equals written line, src/dest swapped.
- Same-cycle pushes to both queues → data-queue request responds first, instr response LATENCY+2 cycles later.
- Push 9 entries into data queue with bank stalled by full_in=1 → full_out rises after 8th, 9th dropped; exactly 8 responses after release.
- Hold full_in=1 during RESP → alloc_out and fields stable until full_in=0, single response delivered.
- Assert rst mid-access → no response, queues empty, READ of any line returns 0.
